// File: rtl/irq_pkg.sv
// Shared types and build defaults for the interrupt gateway.
package irq_pkg;

    typedef enum logic [1:0] {
        GW_IDLE   = 2'd0,
        GW_PEND   = 2'd1,
        GW_FLIGHT = 2'd2
    } gw_state_e;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_EDGE_CNT_WIDTH = 4;

endpackage

// File: rtl/irq_gateway_if.sv
// Gateway bus: raw lines and modes in, completion strobe in, PLIC requests out.
interface irq_gateway_if #(
    parameter int NSOURCES     = 32,
    parameter int SRC_ID_WIDTH = 5
);
    logic [NSOURCES-1:0]     irq_raw_i;
    logic [NSOURCES-1:0]     edge_mode_i;
    logic                    complete_valid_i;
    logic [SRC_ID_WIDTH-1:0] complete_id_i;
    logic [NSOURCES-1:0]     req_o;
    logic [NSOURCES-1:0]     inflight_o;

    modport master (
        output irq_raw_i, edge_mode_i, complete_valid_i, complete_id_i,
        input  req_o, inflight_o
    );

    modport slave (
        input  irq_raw_i, edge_mode_i, complete_valid_i, complete_id_i,
        output req_o, inflight_o
    );
endinterface

// File: rtl/irq_gateway_cell.sv
// One interrupt source: synchroniser, trigger rules, IDLE/PEND/FLIGHT FSM.
// With IRQ_EDGE_COUNT_EN each remembered edge is redelivered; otherwise edges collapse to one.
module irq_gateway_cell
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef IRQ_EDGE_COUNT_EN
    , parameter int EDGE_CNT_WIDTH = DEF_EDGE_CNT_WIDTH
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_raw,
    input  logic edge_mode,
    input  logic complete,
    output logic req,
    output logic inflight
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    gw_state_e              state_q;
    logic                   req_q;
    logic                   inflight_q;
    logic                   sync;
    logic                   edge_seen;
    logic                   stored;
    logic                   trig;
    logic                   busy;

    assign sync      = sync_q[SYNC_STAGES-1];
    assign edge_seen = edge_mode & sync & ~prev_q;
    assign busy      = (state_q != GW_IDLE);
    assign trig      = edge_mode ? (edge_seen | stored) : sync;
    assign req       = req_q;
    assign inflight  = inflight_q;

`ifdef IRQ_EDGE_COUNT_EN
    logic [EDGE_CNT_WIDTH-1:0] cnt_q;

    assign stored = (cnt_q != '0);

    // A fresh edge in IDLE is delivered directly; only a backlog delivery consumes a count.
    always_ff @(posedge clk) begin
        if (rst || !edge_mode) begin
            cnt_q <= '0;
        end else if (edge_seen && busy) begin
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end else if (!busy && !edge_seen && stored) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end
`else
    logic sticky_q;

    assign stored = sticky_q;

    always_ff @(posedge clk) begin
        if (rst || !edge_mode) begin
            sticky_q <= 1'b0;
        end else if (edge_seen && busy) begin
            sticky_q <= 1'b1;
        end else if (!busy) begin
            sticky_q <= 1'b0;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            state_q    <= GW_IDLE;
            req_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
            prev_q <= sync;
            req_q  <= 1'b0;
            unique case (state_q)
                GW_IDLE: begin
                    if (trig) begin
                        state_q <= GW_PEND;
                        req_q   <= 1'b1;
                    end
                end
                GW_PEND: begin
                    state_q    <= GW_FLIGHT;
                    inflight_q <= 1'b1;
                end
                GW_FLIGHT: begin
                    if (complete) begin
                        state_q    <= GW_IDLE;
                        inflight_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= GW_IDLE;
                    inflight_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/irq_gateway.sv
// Interrupt gateway upstream of the PLIC: one independent cell per source.
// Optional build macro IRQ_EDGE_COUNT_EN enables per-source edge counting.
module irq_gateway
    import irq_pkg::*;
#(
    parameter int NSOURCES     = 32,
    parameter int SRC_ID_WIDTH = 5,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
`ifdef IRQ_EDGE_COUNT_EN
    , parameter int EDGE_CNT_WIDTH = DEF_EDGE_CNT_WIDTH
`endif
) (
    input  logic          clk_i,
    input  logic          rst_i,
    irq_gateway_if.slave  bus
);

    logic [NSOURCES-1:0] complete;
    logic [NSOURCES-1:0] req;
    logic [NSOURCES-1:0] inflight;

    // NOTE: default assignment first so the decode can never infer a latch.
    // IDs at or beyond NSOURCES match no bit and are therefore ignored.
    always_comb begin
        complete = '0;
        for (int i = 0; i < NSOURCES; i++) begin
            complete[i] = bus.complete_valid_i && (32'(bus.complete_id_i) == i);
        end
    end

    for (genvar i = 0; i < NSOURCES; i++) begin : g_cell
        irq_gateway_cell #(
            .SYNC_STAGES    (SYNC_STAGES)
`ifdef IRQ_EDGE_COUNT_EN
            , .EDGE_CNT_WIDTH (EDGE_CNT_WIDTH)
`endif
        ) u_cell (
            .clk       (clk_i),
            .rst       (rst_i),
            .irq_raw   (bus.irq_raw_i[i]),
            .edge_mode (bus.edge_mode_i[i]),
            .complete  (complete[i]),
            .req       (req[i]),
            .inflight  (inflight[i])
        );
    end

    assign bus.req_o      = req;
    assign bus.inflight_o = inflight;

endmodule

// File: doc/irq_gateway.md
Name: irq_gateway

Overview:
- Per-source interrupt gateway sitting directly upstream of the PLIC; its `req_o` vector drives the PLIC `src_i` inputs.
- Synchronises raw asynchronous interrupt lines and applies level- or edge-trigger rules per source.
- Delivers each request to the PLIC as a single-cycle pulse, then blocks that source until software signals completion for its ID.
- Prevents a held level from re-flooding PLIC pending; remembers edges that arrive while a request is in flight.

Parameters:
- NSOURCES, 32, number of interrupt sources; must match the PLIC.
- SRC_ID_WIDTH, 5, width of completion ID; 2**SRC_ID_WIDTH >= NSOURCES.
- SYNC_STAGES, 2, synchroniser flop depth per source; legal range 2..4.
- EDGE_CNT_WIDTH, 4, width of the per-source edge counter; used only with IRQ_EDGE_COUNT_EN.

Ports:
- clk_i  input  1  clock; single clock domain.
- rst_i  input  1  reset; synchronous, active-high.
- irq_raw_i  input  NSOURCES  raw asynchronous interrupt lines, active-high.
- edge_mode_i  input  NSOURCES  per source: 1 = rising-edge triggered, 0 = level triggered.
- complete_valid_i  input  1  completion strobe, one cycle per completion.
- complete_id_i  input  SRC_ID_WIDTH  source ID being completed.
- req_o  output  NSOURCES  one-cycle request pulses to the PLIC `src_i`.
- inflight_o  output  NSOURCES  1 while a source is delivered but not yet completed.

Behaviour:
- Reset: rst_i is sampled on the rising edge of clk_i.
  - All synchroniser flops, prev flops, state and counters clear.
  - req_o = 0 and inflight_o = 0 in the cycle after the reset edge.
  - Reset asserted mid-operation discards every in-flight and remembered request.
- Synchroniser: per source, a chain s[0..SYNC_STAGES-1]; sync = s[last]; prev = sync delayed by one cycle.
- Trigger:
  - Level mode: trig = sync.
  - Edge mode: trig = sync & ~prev, plus any remembered edge.
- Per-source state machine (states IDLE, PEND, FLIGHT):
  - IDLE: if trig, go to PEND next cycle; otherwise stay.
  - PEND: req_o[i] = 1 for exactly this one cycle; always go to FLIGHT next cycle.
  - FLIGHT: inflight_o[i] = 1. If complete_valid_i and complete_id_i == i, go to IDLE; otherwise stay.
- Latency: with irq_raw_i[i] stable high, req_o[i] asserts exactly SYNC_STAGES+1 rising edges after the first edge that samples it high (3 for the default).
- Re-trigger after completion:
  - Level mode: if sync is still high in the IDLE cycle, re-enter PEND. Minimum gap between pulses is therefore 2 cycles after completion.
  - Edge mode: a rising edge seen while in PEND or FLIGHT is remembered (see Optional Feature) and triggers PEND from IDLE.
- Completion rules:
  - Completion for a source in IDLE or PEND is ignored, with no state change.
  - complete_id_i >= NSOURCES is ignored.
  - Only one source is completed per cycle.
- Mode change: edge_mode_i is evaluated every cycle. Writing 0 (level) clears that source's remembered edges immediately; state is unaffected.
- Simultaneous events: a new edge in the same cycle as the completing FLIGHT->IDLE is remembered, not lost.
- Source independence: no arbitration and no priority; all sources run in parallel, and multiple req_o bits may pulse in the same cycle.

Optional Feature:
- Macro: IRQ_EDGE_COUNT_EN.
- Defined:
  - Each source has a saturating EDGE_CNT_WIDTH-bit counter.
  - It increments on each edge seen in PEND or FLIGHT, saturating at all-ones.
  - On IDLE with count > 0, go to PEND and decrement.
  - Result: each edge yields one delivery, up to 15 stored.
- Undefined: a single sticky bit per source; any number of edges during PEND/FLIGHT collapse into one re-delivery.

Decomposition:
- Package irq_pkg:
  - enum gw_state_e {GW_IDLE, GW_PEND, GW_FLIGHT}.
  - localparam defaults for SYNC_STAGES and EDGE_CNT_WIDTH.
- Sub-module irq_gateway_cell:
  - One source: synchroniser, edge detect, state machine, counter or sticky bit.
  - Inputs: the decoded completion bit for its source.
- Top: generate-loops NSOURCES cells and decodes complete_valid_i/complete_id_i into a one-hot complete vector.

Test Plan:
- Level basic: raise irq_raw_i[3] and hold -> req_o[3] pulses once at edge 3, inflight_o[3] = 1 afterwards, and no further pulse for 20 cycles with no completion.
- Level re-arm: from the level basic state, complete_id_i = 3 with the line still high -> inflight_o[3] drops, req_o[3] pulses again 2 cycles later. Drop the line and complete -> no further pulse.
- Edge storm: edge_mode_i[5] = 1, apply 3 rising edges on source 5 while in FLIGHT, then complete 3 times.
  - With IRQ_EDGE_COUNT_EN: exactly 3 further pulses.
  - Without it: exactly 1 further pulse.
- Completion filtering: complete ID 7 while source 7 is IDLE, and complete ID 31 with NSOURCES = 8 -> no state change anywhere, req_o = 0.
- Simultaneous: edge on source 0 in the same cycle as the completion of source 0 -> source returns to IDLE, then pulses req_o[0] one cycle later.
- Reset mid-flight: sources 1 and 2 in FLIGHT with a stored edge, assert rst_i for 1 cycle -> inflight_o = 0 and req_o = 0, and no pulse afterwards while lines are low.
